mod_segment_serializer: RTL and testbench

Downstream stage of the per-bit segment calculators in the modulation pipe. It collects the 32-bit segment words produced one per input bit, buffers them in a small FIFO, and streams them out over a valid/ready interface as one frame of `FRAME_LEN` segments. It reports frame completion and activity with the pipe's usual `start`/`valid`/`busy` control trio.

---
 rtl/mod_pipe_pkg.sv | 16 +
 rtl/seg_fifo.sv | 71 +++++++
 rtl/mod_segment_serializer.sv | 124 ++++++++++++
 tb/tb_mod_segment_serializer.sv | 297 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mod_pipe_pkg.sv
// Shared types for the modulation pipe stages.
// Segment word type and the serializer state encoding.
package mod_pipe_pkg;

  localparam int SEG_W = 32;

  typedef logic [SEG_W-1:0] seg_t;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN,
    DONE
  } state_t;

endpackage

// File: rtl/seg_fifo.sv
// Synchronous segment FIFO with registered head word.
// rdata always holds the oldest stored word, or the last one popped.
module seg_fifo #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 8,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              push,
  input  logic [DATA_W-1:0] wdata,
  input  logic              pop,
  output logic [DATA_W-1:0] rdata,
  output logic              full,
  output logic              empty,
  output logic [AW:0]       count
);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic [AW-1:0]     rd_nxt;
  logic              do_push;
  logic              do_pop;
  logic              to_head;

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rd_nxt  = rd_ptr + AW'(1);

  // a pushed word becomes the head when nothing older survives the cycle
  assign to_head = do_push &&
    (empty || (do_pop && count == (AW+1)'(1)));

  // storage array, written only on an accepted push
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= wdata;
    end
  end

  // pointers, occupancy and registered head word
  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      rdata  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (do_pop) begin
        rd_ptr <= rd_nxt;
      end
      unique case ({do_push, do_pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
      if (to_head) begin
        rdata <= wdata;
      end else if (do_pop && count > (AW+1)'(1)) begin
        rdata <= mem[rd_nxt];
      end
    end
  end

endmodule

// File: rtl/mod_segment_serializer.sv
// Collects per-bit segment words and streams one frame out.
// FSM, frame counters and handshake glue around seg_fifo.
module mod_segment_serializer
  import mod_pipe_pkg::*;
#(
  parameter int DATA_W    = SEG_W,
  parameter int DEPTH     = 8,
  parameter int FRAME_LEN = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              seg_valid,
  input  logic [DATA_W-1:0] segment,
  output logic              seg_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_last,
  output logic              valid,
  output logic              busy
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(FRAME_LEN + 1);

  state_t        state_q;
  state_t        state_d;
  logic [CW-1:0] in_cnt;
  logic [CW-1:0] out_cnt;
  logic [AW:0]   fifo_count;
  logic          fifo_full;
  logic          fifo_empty;
  logic          running;
  logic          push;
  logic          pop;
  logic          in_last;

  assign running   = (state_q == RUN) || (state_q == DRAIN);
  assign seg_ready = (state_q == RUN) &&
                     (fifo_count < (AW+1)'(DEPTH));
  assign out_valid = running && !fifo_empty;
  assign pop       = out_valid && out_ready;
  assign push      = seg_valid && seg_ready &&
                     !(fifo_full && pop);
  assign out_last  = out_valid &&
                     (out_cnt == CW'(FRAME_LEN - 1));
  assign in_last   = (in_cnt == CW'(FRAME_LEN - 1));
  assign valid     = (state_q == DONE);
  assign busy      = (state_q != IDLE);

  seg_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .wdata (segment),
    .pop   (pop),
    .rdata (out_data),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  // state register
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // next state: frame end on the last pop wins over fill complete
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d = RUN;
        end
      end
      RUN: begin
        if (pop && out_last) begin
          state_d = DONE;
        end else if (push && in_last) begin
          state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (pop && out_last) begin
          state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // frame in/out counters, cleared only by an honoured start
  always_ff @(posedge clk) begin
    if (!reset) begin
      in_cnt  <= '0;
      out_cnt <= '0;
    end else if (state_q == IDLE && start) begin
      in_cnt  <= '0;
      out_cnt <= '0;
    end else begin
      if (push) begin
        in_cnt <= in_cnt + CW'(1);
      end
      if (pop) begin
        out_cnt <= out_cnt + CW'(1);
      end
    end
  end

endmodule

// File: tb/tb_mod_segment_serializer.sv
// Randomized and directed bench for mod_segment_serializer.
// Queue scoreboard for FRAME_LEN=16, directed frame for FRAME_LEN=4.
module tb_mod_segment_serializer;

  localparam int F  = 16;
  localparam int D  = 8;
  localparam int F4 = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic        seg_valid;
  logic [31:0] segment;
  logic        seg_ready;
  logic [31:0] out_data;
  logic        out_valid;
  logic        out_ready;
  logic        out_last;
  logic        valid;
  logic        busy;

  logic        start4;
  logic        sv4;
  logic [31:0] seg4;
  logic        sr4;
  logic [31:0] od4;
  logic        ov4;
  logic        or4;
  logic        ol4;
  logic        v4o;
  logic        b4;

  int n_checks = 0;
  int n_errors = 0;

  logic [31:0] q[$];
  int          pop_idx = 0;
  int          push_idx = 0;
  int          vcnt = 0;
  bit          acc = 1'b0;

  always #5 clk = ~clk;

  mod_segment_serializer #(
    .DATA_W    (32),
    .DEPTH     (D),
    .FRAME_LEN (F)
  ) u_dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .seg_valid (seg_valid),
    .segment   (segment),
    .seg_ready (seg_ready),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_last  (out_last),
    .valid     (valid),
    .busy      (busy)
  );

  mod_segment_serializer #(
    .DATA_W    (32),
    .DEPTH     (D),
    .FRAME_LEN (F4)
  ) u_dut4 (
    .clk       (clk),
    .reset     (reset),
    .start     (start4),
    .seg_valid (sv4),
    .segment   (seg4),
    .seg_ready (sr4),
    .out_data  (od4),
    .out_valid (ov4),
    .out_ready (or4),
    .out_last  (ol4),
    .valid     (v4o),
    .busy      (b4)
  );

  task automatic chk(input string tag,
                     input logic [63:0] got,
                     input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    acc = seg_valid && seg_ready;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_seg_ready"}, seg_ready, 0);
    chk({tag, "_out_valid"}, out_valid, 0);
    chk({tag, "_out_last"}, out_last, 0);
    chk({tag, "_valid"}, valid, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_out_data"}, out_data, 0);
  endtask

  // scoreboard: words leave in push order, every F-th is last
  always @(negedge clk) begin
    if (!reset) begin
      q.delete();
      pop_idx  = 0;
      push_idx = 0;
      vcnt     = 0;
    end else begin
      chk("out_valid", out_valid, q.size() != 0);
      chk("out_last", out_last,
          (q.size() != 0) && (pop_idx % F == F - 1));
      if (seg_ready) begin
        chk("seg_ready_room",
            (q.size() < D) && (push_idx < F * (vcnt + 1)), 1);
      end
      if (out_valid && out_ready && q.size() != 0) begin
        chk("out_data", out_data, q.pop_front());
        pop_idx++;
      end
      if (valid) begin
        vcnt++;
        chk("frame_pops", pop_idx, F * vcnt);
      end
      if (seg_valid && seg_ready) begin
        q.push_back(segment);
        push_idx++;
      end
    end
  end

  task automatic drive_frame(input int pv, input int pr,
                             input bit mid, input bit at_done);
    int cyc = 0;
    int v0  = vcnt;
    start = 1'b1;
    step();
    start = 1'b0;
    while (vcnt == v0 && cyc < 3000) begin
      if (acc || !seg_valid) begin
        seg_valid = ($urandom_range(99) < pv);
        segment   = $urandom;
      end
      out_ready = ($urandom_range(99) < pr);
      start = (mid && cyc == 6) || (at_done && valid);
      step();
      cyc++;
    end
    start = 1'b0;
    chk("frame_count", vcnt - v0, 1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] w4 [4];
    int n;
    int v0;
    w4[0] = 32'h11;
    w4[1] = 32'h22;
    w4[2] = 32'h33;
    w4[3] = 32'h44;
    reset = 1'b0;
    start = 1'b0;
    seg_valid = 1'b0;
    segment = '0;
    out_ready = 1'b0;
    start4 = 1'b0;
    sv4 = 1'b0;
    seg4 = '0;
    or4 = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk_reset_vals("rst");
    reset = 1'b1;
    step();

    begin : dir4
      int k = 0;
      int p = 0;
      int nv = 0;
      start4 = 1'b1;
      @(posedge clk); #1;
      start4 = 1'b0;
      for (int c = 0; c < 14; c++) begin
        sv4  = (k < F4);
        seg4 = (k < F4) ? w4[k] : 32'h0;
        @(negedge clk);
        if (ov4) begin
          if (p < F4) begin
            chk("d4_data", od4, w4[p]);
            chk("d4_last", ol4, p == F4 - 1);
          end else begin
            chk("d4_extra_word", p, F4 - 1);
          end
          p++;
        end else begin
          chk("d4_last_idle", ol4, 0);
        end
        if (v4o) begin
          nv++;
          chk("d4_valid_cycle", c, F4 + 1);
        end
        if (c == F4 + 2) chk("d4_busy_after", b4, 0);
        if (sv4 && sr4) k++;
        @(posedge clk); #1;
      end
      sv4 = 1'b0;
      chk("d4_pops", p, F4);
      chk("d4_valid_cnt", nv, 1);
    end

    // backpressure: fill to depth, then drain with upstream held in DRAIN
    v0 = vcnt;
    out_ready = 1'b0;
    seg_valid = 1'b1;
    segment = 0;
    start = 1'b1;
    step();
    start = 1'b0;
    n = 0;
    for (int i = 0; i < 30 && seg_ready; i++) begin
      step();
      if (acc) begin n++; segment = n; end
    end
    chk("fill_count", n, D);
    out_ready = 1'b1;
    for (int i = 0; i < 200 && vcnt == v0; i++) begin
      step();
      if (acc) begin n++; segment = n; end
      if (n == F && busy && !valid)
        chk("drain_seg_ready", seg_ready, 0);
    end
    chk("bp_frames", vcnt - v0, 1);
    chk("bp_pushes", n, F);
    seg_valid = 1'b0;
    step();

    // start pulsed in RUN and in DONE has no effect
    drive_frame(80, 80, 1'b1, 1'b1);
    step();
    chk("post_done_busy", busy, 0);
    chk("post_done_ready", seg_ready, 0);
    step();
    step();
    chk("no_second_frame", busy, 0);
    chk("no_second_ov", out_valid, 0);
    seg_valid = 1'b0;
    step();

    // reset with three words buffered
    out_ready = 1'b0;
    seg_valid = 1'b1;
    segment = $urandom;
    start = 1'b1;
    step();
    start = 1'b0;
    n = 0;
    for (int i = 0; i < 20 && n < 3; i++) begin
      step();
      if (acc) begin n++; segment = $urandom; end
    end
    seg_valid = 1'b0;
    chk("pre_reset_ov", out_valid, 1);
    reset = 1'b0;
    step();
    reset = 1'b1;
    chk_reset_vals("midrst");
    step();
    drive_frame(100, 100, 1'b0, 1'b0);

    // back-to-back random frames
    v0 = vcnt;
    for (int f = 0; f < 10; f++) begin
      drive_frame(60, 60, 1'b0, 1'b0);
    end
    chk("rand_valid_total", vcnt - v0, 10);
    seg_valid = 1'b0;
    out_ready = 1'b1;
    step();
    step();

    $display("Simulation finished: %0d checks, %0d errors",
             n_checks, n_errors);
    $finish;
  end

endmodule
